// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register file write-port controller with post-reset clear and round-robin write-back arbitration
module regfile_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    input  logic [AW-1:0]   req0_addr,
    input  logic [XLEN-1:0] req0_data,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [AW-1:0]   req1_addr,
    input  logic [XLEN-1:0] req1_data,
    output logic            req1_ready,
    output logic            WE3,
    output logic [AW-1:0]   A3,
    output logic [XLEN-1:0] WD3,
    output logic            init_done,
    output logic            conflict
);

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic            last_q, last_d;
    logic            we3_q, we3_d;
    logic [AW-1:0]   a3_q, a3_d;
    logic [XLEN-1:0] wd3_q, wd3_d;
    logic            conflict_q, conflict_d;
    logic            run;
    logic            grant0;
    logic            grant1;

    // last_q = 1 means requester 1 was granted most recently, so requester 0 wins a tie
    always_comb begin
        run    = (state_q == S_RUN);
        grant0 = run && req0_valid && (!req1_valid || last_q);
        grant1 = run && req1_valid && (!req0_valid || !last_q);

        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        last_d     = last_q;
        we3_d      = 1'b0;
        a3_d       = a3_q;
        wd3_d      = wd3_q;
        conflict_d = run && req0_valid && req1_valid;

        if (!run) begin
            we3_d     = 1'b1;
            a3_d      = clr_cnt_q;
            wd3_d     = '0;
            clr_cnt_d = clr_cnt_q + AW'(1);
            if (clr_cnt_q == AW'(NREG - 1)) begin
                state_d = S_RUN;
            end
        end else if (grant0) begin
            we3_d  = (req0_addr != '0);
            a3_d   = req0_addr;
            wd3_d  = req0_data;
            last_d = 1'b0;
        end else if (grant1) begin
            we3_d  = (req1_addr != '0);
            a3_d   = req1_addr;
            wd3_d  = req1_data;
            last_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_CLEAR;
            clr_cnt_q  <= '0;
            last_q     <= 1'b1;
            we3_q      <= 1'b0;
            a3_q       <= '0;
            wd3_q      <= '0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            last_q     <= last_d;
            we3_q      <= we3_d;
            a3_q       <= a3_d;
            wd3_q      <= wd3_d;
            conflict_q <= conflict_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign WE3        = we3_q;
    assign A3         = a3_q;
    assign WD3        = wd3_q;
    assign init_done  = run;
    assign conflict   = conflict_q;

endmodule
